// File: rtl/vga_sync.sv
// VGA timing generator: free-running x/y raster counters, sync decode, and a
// colour/sync alignment pipeline ending in a blanked output register stage.
module vga_sync #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic       CLK_DRAW,
    input  logic       RST_N,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       VIDEO_ON,
    output logic       FRAME_TICK,
    input  logic [4:0] RED,
    input  logic [5:0] GREEN,
    input  logic [4:0] BLUE,
    output logic [4:0] VGA_RED,
    output logic [5:0] VGA_GREEN,
    output logic [4:0] VGA_BLUE,
    output logic       HSYNC,
    output logic       VSYNC
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    typedef logic [PIPE_DELAY-1:0] pipe_t;

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       x_wrap;
    logic       hsync_raw, vsync_raw;
    pipe_t      hs_pipe_q, hs_pipe_d;
    pipe_t      vs_pipe_q, vs_pipe_d;
    pipe_t      von_pipe_q, von_pipe_d;
    logic       hs_dly, vs_dly, von_dly;

    // Raster counters
    always_comb begin
        x_wrap = (x_q == H_LAST);
        x_d    = x_wrap ? 10'd0 : x_q + 10'd1;
        y_d    = y_q;
        if (x_wrap) begin
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
    end

    assign x = x_q;
    assign y = y_q;

    // Zero-latency decodes of the current raster position
    always_comb begin
        VIDEO_ON   = (x_q < H_VIS_END) && (y_q < V_VIS_END);
        FRAME_TICK = x_wrap && (y_q == V_LAST);
        hsync_raw  = !((x_q >= H_SYNC_BEG) && (x_q < H_SYNC_END));
        vsync_raw  = !((y_q >= V_SYNC_BEG) && (y_q < V_SYNC_END));
    end

    // Bit 0 is the newest stage; the MSB lines up with the colour inputs.
    always_comb begin
        hs_pipe_d     = hs_pipe_q << 1;
        vs_pipe_d     = vs_pipe_q << 1;
        von_pipe_d    = von_pipe_q << 1;
        hs_pipe_d[0]  = hsync_raw;
        vs_pipe_d[0]  = vsync_raw;
        von_pipe_d[0] = VIDEO_ON;
    end

    assign hs_dly  = hs_pipe_q[PIPE_DELAY-1];
    assign vs_dly  = vs_pipe_q[PIPE_DELAY-1];
    assign von_dly = von_pipe_q[PIPE_DELAY-1];

    always_ff @(posedge CLK_DRAW or negedge RST_N) begin
        if (!RST_N) begin
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            von_pipe_q <= '0;
            HSYNC      <= 1'b1;
            VSYNC      <= 1'b1;
            VGA_RED    <= '0;
            VGA_GREEN  <= '0;
            VGA_BLUE   <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            von_pipe_q <= von_pipe_d;
            HSYNC      <= hs_dly;
            VSYNC      <= vs_dly;
            // Blank colour whenever the aligned pixel is outside the visible area
            VGA_RED    <= von_dly ? RED   : 5'd0;
            VGA_GREEN  <= von_dly ? GREEN : 6'd0;
            VGA_BLUE   <= von_dly ? BLUE  : 5'd0;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench: a default-timing instance for line-level checks and a tiny-timing,
// PIPE_DELAY=3 instance for frame, vsync, and pipeline-alignment checks.
module tb_vga_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance
    logic       rst_n;
    logic [9:0] x, y;
    logic       video_on, frame_tick, hsync, vsync;
    logic [4:0] red, vga_red;
    logic [5:0] green, vga_green;
    logic [4:0] blue, vga_blue;

    // Small instance: H 16/2/3/2 (23), V 6/1/2/1 (10), PIPE_DELAY 3
    logic       rst_s_n;
    logic [9:0] xs, ys;
    logic       video_on_s, frame_tick_s, hsync_s, vsync_s;
    logic [4:0] red_s, vga_red_s;
    logic [5:0] green_s, vga_green_s;
    logic [4:0] blue_s, vga_blue_s;
    logic [9:0] h0, h1, h2, h3;

    vga_sync dut (
        .CLK_DRAW(clk), .RST_N(rst_n), .x(x), .y(y), .VIDEO_ON(video_on),
        .FRAME_TICK(frame_tick), .RED(red), .GREEN(green), .BLUE(blue),
        .VGA_RED(vga_red), .VGA_GREEN(vga_green), .VGA_BLUE(vga_blue),
        .HSYNC(hsync), .VSYNC(vsync)
    );

    vga_sync #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIPE_DELAY(3)
    ) dut_s (
        .CLK_DRAW(clk), .RST_N(rst_s_n), .x(xs), .y(ys), .VIDEO_ON(video_on_s),
        .FRAME_TICK(frame_tick_s), .RED(red_s), .GREEN(green_s), .BLUE(blue_s),
        .VGA_RED(vga_red_s), .VGA_GREEN(vga_green_s), .VGA_BLUE(vga_blue_s),
        .HSYNC(hsync_s), .VSYNC(vsync_s)
    );

    // Advance one edge, then drive the small instance's red as f(x three clocks back)
    task automatic tick();
        @(posedge clk);
        #1;
        h3 = h2; h2 = h1; h1 = h0; h0 = xs;
        red_s = 5'(h3) + 5'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_s_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({x, y} !== 20'd0) begin
            n_fail++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", x, y);
        end
        n_checks++;
        if ({video_on, frame_tick} !== 2'b10) begin
            n_fail++; $display("FAIL reset_flags: got von=%b ft=%b expected 1 0", video_on, frame_tick);
        end
        n_checks++;
        if ({hsync, vsync, vga_red, vga_green, vga_blue} !== {2'b11, 16'd0}) begin
            n_fail++; $display("FAIL reset_out: got hs=%b vs=%b rgb=%0d/%0d/%0d expected 1 1 0/0/0",
                               hsync, vsync, vga_red, vga_green, vga_blue);
        end
        n_checks++;
        if ({xs, ys, hsync_s, vsync_s, vga_red_s} !== {20'd0, 2'b11, 5'd0}) begin
            n_fail++; $display("FAIL reset_small: got x=%0d y=%0d hs=%b vs=%b r=%0d expected 0 0 1 1 0",
                               xs, ys, hsync_s, vsync_s, vga_red_s);
        end
        @(negedge clk);
        rst_n = 1'b1; rst_s_n = 1'b1;
    endtask

    task automatic test_count();
        for (int k = 1; k <= 800; k++) begin
            logic [9:0] ex;
            logic [9:0] ey;
            tick();
            ex = (k == 800) ? 10'd0 : 10'(k);
            ey = (k == 800) ? 10'd1 : 10'd0;
            n_checks++;
            if (x !== ex || y !== ey) begin
                n_fail++; $display("FAIL count_xy k=%0d: got %0d,%0d expected %0d,%0d", k, x, y, ex, ey);
            end
            n_checks++;
            if (video_on !== (ex < 10'd640) || frame_tick !== 1'b0) begin
                n_fail++; $display("FAIL count_von k=%0d: got von=%b ft=%b expected %b 0",
                                   k, video_on, frame_tick, ex < 10'd640);
            end
        end
    endtask

    task automatic test_hsync();
        int guard = 0;
        int c656  = -1;
        int cfall = -1;
        int low   = 0;
        while (x != 10'd650 && guard < 1000) begin tick(); guard++; end
        n_checks++;
        if (guard >= 1000) begin
            n_fail++; $display("FAIL hsync_sync: got timeout expected x=650");
        end
        for (int j = 0; j < 120; j++) begin
            if (x == 10'd656 && c656 < 0) c656 = j;
            if (hsync === 1'b0) begin
                if (cfall < 0) cfall = j;
                low++;
            end
            tick();
        end
        n_checks++;
        if (cfall - c656 !== 2) begin
            n_fail++; $display("FAIL hsync_start: got %0d expected 2 clocks after x=656", cfall - c656);
        end
        n_checks++;
        if (low !== 96) begin
            n_fail++; $display("FAIL hsync_width: got %0d expected 96", low);
        end
    endtask

    task automatic test_colour();
        int guard = 0;
        int nz    = 0;
        while (x != 10'd2 && guard < 1000) begin tick(); guard++; end
        n_checks++;
        if (guard >= 1000) begin
            n_fail++; $display("FAIL colour_sync: got timeout expected x=2");
        end
        // Observation i reflects the pixel at x=i of a visible line
        for (int i = 0; i < 800; i++) begin
            logic [15:0] exp_rgb;
            exp_rgb = (i < 640) ? {5'd31, 6'd63, 5'd31} : 16'd0;
            n_checks++;
            if ({vga_red, vga_green, vga_blue} !== exp_rgb) begin
                n_fail++; $display("FAIL colour_px i=%0d: got %0d/%0d/%0d expected %h",
                                   i, vga_red, vga_green, vga_blue, exp_rgb);
            end
            if (vga_red != 5'd0) nz++;
            tick();
        end
        n_checks++;
        if (nz !== 640) begin
            n_fail++; $display("FAIL colour_count: got %0d expected 640", nz);
        end
    endtask

    task automatic test_frame_small();
        int guard = 0;
        int ticks = 0;
        int at    = -1;
        int vis   = 0;
        int nz    = 0;
        while (!(xs == 10'd0 && ys == 10'd0) && guard < 300) begin tick(); guard++; end
        n_checks++;
        if (guard >= 300) begin
            n_fail++; $display("FAIL frame_sync: got timeout expected x=0 y=0");
        end
        for (int i = 0; i < 230; i++) begin
            if (frame_tick_s === 1'b1) begin
                ticks++; at = i;
                n_checks++;
                if (xs !== 10'd22 || ys !== 10'd9) begin
                    n_fail++; $display("FAIL frame_pos: got %0d,%0d expected 22,9", xs, ys);
                end
            end
            if (video_on_s === 1'b1) vis++;
            if (vga_red_s != 5'd0) nz++;
            tick();
        end
        n_checks++;
        if (ticks !== 1 || at !== 229) begin
            n_fail++; $display("FAIL frame_ticks: got %0d at %0d expected 1 at 229", ticks, at);
        end
        n_checks++;
        if (xs !== 10'd0 || ys !== 10'd0) begin
            n_fail++; $display("FAIL frame_wrap: got %0d,%0d expected 0,0", xs, ys);
        end
        n_checks++;
        if (vis !== 96 || nz !== 96) begin
            n_fail++; $display("FAIL frame_visible: got von=%0d rgb=%0d expected 96 96", vis, nz);
        end
    endtask

    task automatic test_vsync_small();
        int guard = 0;
        int first = -1;
        int low   = 0;
        while (!(xs == 10'd0 && ys == 10'd0) && guard < 300) begin tick(); guard++; end
        // Raw vsync covers lines 7..8 (i=161..206), seen 4 clocks later
        for (int i = 0; i < 230; i++) begin
            if (vsync_s === 1'b0) begin
                if (first < 0) first = i;
                low++;
            end
            tick();
        end
        n_checks++;
        if (first !== 165) begin
            n_fail++; $display("FAIL vsync_start: got %0d expected 165", first);
        end
        n_checks++;
        if (low !== 46) begin
            n_fail++; $display("FAIL vsync_width: got %0d expected 46", low);
        end
    endtask

    task automatic test_pipe_small();
        int guard = 0;
        while (!(xs == 10'd0 && ys == 10'd1) && guard < 300) begin tick(); guard++; end
        n_checks++;
        if (guard >= 300) begin
            n_fail++; $display("FAIL pipe_sync: got timeout expected x=0 y=1");
        end
        for (int i = 0; i < 23; i++) begin
            logic [4:0] er;
            logic       eh;
            er = (i >= 4 && i < 20) ? 5'(i - 3) : 5'd0;
            eh = !(i == 0 || i == 1 || i == 22);
            n_checks++;
            if (vga_red_s !== er) begin
                n_fail++; $display("FAIL pipe_red i=%0d: got %0d expected %0d", i, vga_red_s, er);
            end
            n_checks++;
            if (hsync_s !== eh) begin
                n_fail++; $display("FAIL pipe_hsync i=%0d: got %b expected %b", i, hsync_s, eh);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (x != 10'd400 && guard < 1000) begin tick(); guard++; end
        n_checks++;
        if (vga_red !== 5'd31) begin
            n_fail++; $display("FAIL mid_pre_rgb: got %0d expected 31", vga_red);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({x, y, hsync, vsync, vga_red, vga_green, vga_blue} !== {20'd0, 2'b11, 16'd0}) begin
            n_fail++; $display("FAIL mid_reset: got x=%0d y=%0d hs=%b vs=%b rgb=%0d/%0d/%0d expected 0 0 1 1 0",
                               x, y, hsync, vsync, vga_red, vga_green, vga_blue);
        end
        guard = 0;
        while (!(xs == 10'd0 && ys == 10'd8) && guard < 300) begin tick(); guard++; end
        n_checks++;
        if (hsync_s !== 1'b0 || vsync_s !== 1'b0) begin
            n_fail++; $display("FAIL mid_pre_sync: got hs=%b vs=%b expected 0 0", hsync_s, vsync_s);
        end
        #3 rst_s_n = 1'b0;
        #1;
        n_checks++;
        if ({xs, ys, hsync_s, vsync_s} !== {20'd0, 2'b11}) begin
            n_fail++; $display("FAIL mid_reset_small: got x=%0d y=%0d hs=%b vs=%b expected 0 0 1 1",
                               xs, ys, hsync_s, vsync_s);
        end
        @(negedge clk);
        rst_n = 1'b1; rst_s_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (x !== 10'(k) || y !== 10'd0 || xs !== 10'(k) || ys !== 10'd0) begin
                n_fail++; $display("FAIL mid_resume k=%0d: got %0d,%0d / %0d,%0d expected %0d,0",
                                   k, x, y, xs, ys, k);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; rst_s_n = 1'b0;
        red = 5'd31; green = 6'd63; blue = 5'd31;
        red_s = 5'd0; green_s = 6'd0; blue_s = 5'd0;
        h0 = '0; h1 = '0; h2 = '0; h3 = '0;
        test_reset();
        test_count();
        test_hsync();
        test_colour();
        test_frame_small();
        test_vsync_small();
        test_pipe_small();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
